spm_sequencer: RTL and testbench

SPM_SEQUENCER -- requirements
Module: spm_sequencer

---
 rtl/spm_sequencer_if.sv | 26 ++
 rtl/spm_sequencer.sv | 93 +++++++++
 tb/tb_spm_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spm_sequencer_if.sv
// Handshake and serial-datapath signals of the signed serial-parallel multiply sequencer.
// The requester side (master) drives the operands and the datapath's serial product bit.
interface spm_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     mp;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 spm_clr;
    logic [WIDTH-1:0]     spm_x;
    logic                 spm_y;
    logic                 spm_p;

    modport master (
        output start, mc, mp, spm_p,
        input  busy, done, product, spm_clr, spm_x, spm_y
    );

    modport slave (
        input  start, mc, mp, spm_p,
        output busy, done, product, spm_clr, spm_x, spm_y
    );
endinterface

// File: rtl/spm_sequencer.sv
// Sign-magnitude wrapper around an unsigned serial-parallel multiplier: feeds |mc| and |mp|,
// collects the product LSB-first and re-applies the sign with a serial two's-complement stage.
module spm_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    spm_sequencer_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW) + 1;
    localparam logic [CW-1:0] LAST = CW'(PW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] y_sr;
    logic [PW-1:0]   acc;
    logic            neg;
    logic            f;
    logic            s_bit;

    // Unsigned magnitude; the most negative value maps onto 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Serial negate: pass bits up to and including the first 1, invert every bit after it.
    assign s_bit = bus.spm_p ^ (neg & f);

    // NOTE: every output is a register written in this one block, so busy/done/spm_* never glitch
    // and the async reset clears them in the same place as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            y_sr        <= '0;
            acc         <= '0;
            neg         <= 1'b0;
            f           <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
            bus.spm_clr <= 1'b0;
            bus.spm_x   <= '0;
            bus.spm_y   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= LOAD;
                        bus.busy    <= 1'b1;
                        bus.spm_clr <= 1'b1;
                        bus.spm_x   <= mag(bus.mc);
                        y_sr        <= mag(bus.mp);
                        neg         <= bus.mc[WIDTH-1] ^ bus.mp[WIDTH-1];
                        cnt         <= '0;
                        f           <= 1'b0;
                    end
                end
                LOAD: begin
                    state       <= RUN;
                    bus.spm_clr <= 1'b0;
                    bus.spm_y   <= y_sr[0];
                    y_sr        <= y_sr >> 1;
                    acc         <= '0;
                end
                RUN: begin
                    acc <= {s_bit, acc[PW-1:1]};
                    f   <= f | bus.spm_p;
                    if (cnt == LAST) begin
                        state       <= DONE;
                        bus.product <= {s_bit, acc[PW-1:1]};
                        bus.done    <= 1'b1;
                        bus.spm_y   <= 1'b0;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        // y_sr is empty after WIDTH shifts, so the upper half of RUN feeds zeros.
                        bus.spm_y <= y_sr[0];
                        y_sr      <= y_sr >> 1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_sequencer.sv
// Directed bench for spm_sequencer with a behavioural unsigned serial-parallel multiplier
// supplying spm_p; expected products are hand-computed signed 8x8 results.
module tb_spm_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    spm_sequencer_if #(.WIDTH(W)) bus ();
    spm_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Shift-add model: in cycle k, add x<<k when y is 1; bit k is final from then on.
    logic [2*W-1:0] m_acc;
    logic [3:0]     m_k;
    logic [2*W-1:0] m_sum;
    assign m_sum     = m_acc + (bus.spm_y ? ({{W{1'b0}}, bus.spm_x} << m_k) : '0);
    assign bus.spm_p = m_sum[m_k];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_acc <= '0;
            m_k   <= '0;
        end else if (bus.spm_clr) begin
            m_acc <= '0;
            m_k   <= '0;
        end else begin
            m_acc <= m_sum;
            if (m_k != 4'd15) m_k <= m_k + 1'b1;
        end
    end

    // Runs one request from a negedge and observes 60 edges; edge 1 samples start.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] prod, output int lat,
                         output logic [2*W-1:0] yseq, output int clr_cnt,
                         output int done_cnt, output int busy_lo);
        int n;
        bus.mc = a;
        bus.mp = b;
        bus.start = 1'b1;
        prod = '0; lat = 0; yseq = '0; clr_cnt = 0; done_cnt = 0; busy_lo = 0;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n >= 2 && n <= 17) yseq[n-2] = bus.spm_y;
            if (bus.spm_clr) clr_cnt++;
            if (n <= 18 && !bus.busy) busy_lo++;
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat  = n;
                    prod = bus.product;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mc = '0; bus.mp = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.busy, bus.done, bus.spm_clr, bus.spm_y} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done/clr/y=%b required 0000",
                     {bus.busy, bus.done, bus.spm_clr, bus.spm_y});
        end
        tests++;
        if (bus.spm_x !== 8'h00 || bus.product !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: spm_x=%h product=%h required 00/0000", bus.spm_x, bus.product);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] p, ys; int lat, cc, dc, bl;
        do_op(8'd5, 8'd3, p, lat, ys, cc, dc, bl);
        tests++; if (lat !== 18) begin fails++; $display("FAIL basic_latency: %0d required 18", lat); end
        tests++; if (p !== 16'h000F) begin fails++; $display("FAIL basic_product: %h required 000f", p); end
        tests++; if (bus.spm_x !== 8'd5) begin fails++; $display("FAIL basic_spm_x: %h required 05", bus.spm_x); end
        tests++; if (ys !== 16'h0003) begin fails++; $display("FAIL basic_y_seq: %h required 0003", ys); end
        tests++; if (cc !== 1) begin fails++; $display("FAIL basic_clr_cycles: %0d required 1", cc); end
        tests++; if (dc !== 1) begin fails++; $display("FAIL basic_done_count: %0d required 1", dc); end
        tests++; if (bl !== 0) begin fails++; $display("FAIL basic_busy: low %0d cycles required 0", bl); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: %b required 0", bus.busy); end
    endtask

    task automatic test_negative();
        logic [15:0] p, ys; int lat, cc, dc, bl;
        do_op(8'hFB, 8'd3, p, lat, ys, cc, dc, bl);
        tests++; if (p !== 16'hFFF1) begin fails++; $display("FAIL neg_product: %h required fff1", p); end
        tests++; if (bus.spm_x !== 8'd5) begin fails++; $display("FAIL neg_spm_x: %h required 05", bus.spm_x); end
        tests++; if (lat !== 18) begin fails++; $display("FAIL neg_latency: %0d required 18", lat); end
    endtask

    task automatic test_extremes();
        logic [15:0] p, ys; int lat, cc, dc, bl;
        do_op(8'h80, 8'h80, p, lat, ys, cc, dc, bl);
        tests++; if (p !== 16'h4000) begin fails++; $display("FAIL min_min_product: %h required 4000", p); end
        tests++; if (bus.spm_x !== 8'h80) begin fails++; $display("FAIL min_spm_x: %h required 80", bus.spm_x); end
        tests++; if (ys !== 16'h0080) begin fails++; $display("FAIL min_y_seq: %h required 0080", ys); end
        do_op(8'h7F, 8'h80, p, lat, ys, cc, dc, bl);
        tests++; if (p !== 16'hC080) begin fails++; $display("FAIL max_min_product: %h required c080", p); end
        tests++; if (bus.spm_x !== 8'h7F) begin fails++; $display("FAIL max_spm_x: %h required 7f", bus.spm_x); end
    endtask

    task automatic test_zero();
        logic [15:0] p, ys; int lat, cc, dc, bl;
        do_op(8'h00, 8'hF9, p, lat, ys, cc, dc, bl);
        tests++; if (p !== 16'h0000) begin fails++; $display("FAIL zero_product: %h required 0000", p); end
        tests++; if (dc !== 1) begin fails++; $display("FAIL zero_done_count: %0d required 1", dc); end
        tests++; if (lat !== 18) begin fails++; $display("FAIL zero_latency: %0d required 18", lat); end
    endtask

    task automatic test_back_to_back();
        int n, d, drops;
        int dn [3];
        logic [15:0] dp [3];
        bus.mc = 8'd2; bus.mp = 8'hFE; bus.start = 1'b1;
        n = 0; d = 0; drops = 0;
        for (int i = 0; i < 3; i++) begin dn[i] = 0; dp[i] = '0; end
        while (n < 75) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 40) bus.start = 1'b0;
            if (bus.done) begin
                if (d < 3) begin dn[d] = n; dp[d] = bus.product; end
                d++;
            end
            if (!bus.busy && n != 19 && n != 38 && n < 57) drops++;
        end
        tests++; if (d !== 3) begin fails++; $display("FAIL b2b_done_count: %0d required 3", d); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (dn[i] !== 18 + 19 * i) begin
                fails++; $display("FAIL b2b_done_edge%0d: %0d required %0d", i, dn[i], 18 + 19 * i);
            end
            tests++;
            if (dp[i] !== 16'hFFFC) begin
                fails++; $display("FAIL b2b_product%0d: %h required fffc", i, dp[i]);
            end
        end
        tests++; if (drops !== 0) begin fails++; $display("FAIL b2b_busy: dropped %0d cycles required 0", drops); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p, ys; int lat, cc, dc, bl, n, stray;
        bus.mc = 8'd3; bus.mp = 8'd3; bus.start = 1'b1;
        n = 0;
        while (n < 8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.spm_clr, bus.spm_y} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_ctrl: busy/done/clr/y=%b required 0000",
                     {bus.busy, bus.done, bus.spm_clr, bus.spm_y});
        end
        tests++;
        if (bus.spm_x !== 8'h00 || bus.product !== 16'h0000) begin
            fails++;
            $display("FAIL abort_data: spm_x=%h product=%h required 00/0000", bus.spm_x, bus.product);
        end
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        tests++; if (stray !== 0) begin fails++; $display("FAIL abort_no_done: %0d active cycles required 0", stray); end
        rst = 1'b1;
        do_op(8'd4, 8'd4, p, lat, ys, cc, dc, bl);
        tests++; if (p !== 16'h0010) begin fails++; $display("FAIL recover_product: %h required 0010", p); end
        tests++; if (lat !== 18) begin fails++; $display("FAIL recover_latency: %0d required 18", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
